// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip SRAM with independent read and write FSMs.
// Supports FIXED and INCR bursts, byte-lane writes, and SLVERR when wlast does not match the burst length.
module axi_sram_slave #(
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic [1:0]  arlock_i,
  input  logic [3:0]  arcache_i,
  input  logic [2:0]  arprot_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [7:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic [1:0]  awlock_i,
  input  logic [3:0]  awcache_i,
  input  logic [2:0]  awprot_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_LAST = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

  logic [31:0] mem_q [MEM_WORDS] = '{default: 32'h0000_0000};

  r_state_e         r_state_q, r_state_d;
  logic             arready_q, arready_d;
  logic [3:0]       rid_q, rid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q;
  logic             rlast_q, rlast_d;
  logic             rvalid_q, rvalid_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [7:0]       rlen_q, rlen_d;
  logic [7:0]       rbeat_q, rbeat_d;
  logic             rfixed_q, rfixed_d;
  logic [3:0]       rwait_q, rwait_d;

  w_state_e         w_state_q, w_state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic [3:0]       bid_lat_q, bid_lat_d;
  logic [3:0]       bid_q, bid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             bvalid_q, bvalid_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wlen_q, wlen_d;
  logic [7:0]       wbeat_q, wbeat_d;
  logic             wfixed_q, wfixed_d;
  logic             werr_q, werr_d;
  logic             mem_we_s;

  logic unused_s;
  assign unused_s = ^{arsize_i, arlock_i, arcache_i, arprot_i, awsize_i, awlock_i, awcache_i,
                      awprot_i, wid_i, araddr_i[31:IDX_W+2], araddr_i[1:0],
                      awaddr_i[31:IDX_W+2], awaddr_i[1:0]};

  // Read FSM next state: a beat is loaded from memory whenever nothing is pending or the current one is taken.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rvalid_d  = rvalid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rfixed_d  = rfixed_q;
    rwait_d   = rwait_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid_i && arready_q) begin
          rid_d     = arid_i;
          ridx_d    = araddr_i[IDX_W+1:2];
          rlen_d    = arlen_i;
          rfixed_d  = (arburst_i == 2'b00);
          rbeat_d   = 8'd0;
          rwait_d   = 4'd0;
          arready_d = 1'b0;
          r_state_d = (READ_LATENCY > 0) ? R_WAIT : R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_WAIT: begin
        if (rwait_q == LAT_LAST) begin
          r_state_d = R_DATA;
        end else begin
          rwait_d = rwait_q + 4'd1;
        end
      end
      R_DATA: begin
        if (!rvalid_q || (rready_i && !rlast_q)) begin
          rvalid_d = 1'b1;
          rdata_d  = mem_q[ridx_q];
          rlast_d  = (rbeat_q == rlen_q);
          rbeat_d  = rbeat_q + 8'd1;
          ridx_d   = rfixed_q ? ridx_q : ridx_q + IDX_ONE;
        end else if (rready_i) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Write FSM next state: one beat per wvalid/wready, error flag sticky until the response.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bid_lat_d = bid_lat_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wfixed_d  = wfixed_q;
    werr_d    = werr_q;
    mem_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid_i && awready_q) begin
          bid_lat_d = awid_i;
          widx_d    = awaddr_i[IDX_W+1:2];
          wlen_d    = awlen_i;
          wfixed_d  = (awburst_i == 2'b00);
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end else begin
          awready_d = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid_i && wready_q) begin
          mem_we_s = ~rst_i;
          werr_d   = werr_q | (wlast_i != (wbeat_q == wlen_q));
          wbeat_d  = wbeat_q + 8'd1;
          widx_d   = wfixed_q ? widx_q : widx_q + IDX_ONE;
          if (wbeat_q == wlen_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = bid_lat_q;
            bresp_d   = werr_d ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end else begin
            wready_d = 1'b1;
          end
        end else begin
          wready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready_i) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers for both channels; reset forces every handshake output low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rbeat_q   <= 8'd0;
      rfixed_q  <= 1'b0;
      rwait_q   <= 4'd0;
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bid_lat_q <= 4'd0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wbeat_q   <= 8'd0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= 2'b00;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rfixed_q  <= rfixed_d;
      rwait_q   <= rwait_d;
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bid_lat_q <= bid_lat_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wfixed_q  <= wfixed_d;
      werr_q    <= werr_d;
    end
  end

  // Byte-lane write port; a read sampling the same word at this edge still sees the old data.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_i[i]) begin
          mem_q[widx_q][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign arready_o = arready_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
  assign rvalid_o  = rvalid_q;
  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign bvalid_o  = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: randomized bursts against an array-based memory model.
module tb_axi_sram_slave;
  localparam int MEM_WORDS = 1024;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_data [256];
  logic        rd_last [256];
  int rd_count, rd_lat, rd_gaps, rd_stab;
  logic [3:0] rd_id;
  logic [1:0] rd_resp;
  logic [1:0] wr_resp;
  logic [3:0] wr_bid;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_WORDS(MEM_WORDS), .READ_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arlock_i(arlock), .arcache_i(arcache), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awlock_i(awlock), .awcache_i(awcache), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word index of beat b: FIXED stays put, anything else steps by one word modulo the depth.
  function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
    int base;
    base = int'((addr >> 2) % MEM_WORDS);
    return (burst == 2'b00) ? base : (base + b) % MEM_WORDS;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    for (int b = 0; b <= int'(len); b++) begin
      int k;
      k = beat_idx(addr, burst, b);
      for (int l = 0; l < 4; l++) begin
        if (ws[b][l]) model_mem[k][8*l +: 8] = wd[b][8*l +: 8];
      end
    end
  endtask

  task automatic ar_req(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                        input logic [3:0] id, output bit ok);
    logic hs;
    araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2; arvalid = 1'b1;
    ok = 1'b0;
    for (int g = 0; g < 50 && !ok; g++) begin
      hs = arready;
      tick();
      ok = hs;
    end
    arvalid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL ar_handshake: arready never seen, required 1");
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input int mode);
    bit ok;
    int cyc;
    logic pv, pr, pl;
    logic [31:0] pd;
    rd_count = 0; rd_lat = -1; rd_gaps = 0; rd_stab = 0; rd_resp = 2'b00; rd_id = 4'd0;
    ar_req(addr, len, burst, id, ok);
    if (!ok) return;
    cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'd0; rready = 1'b0;
    while (rd_count <= int'(len) && cyc < 600) begin
      if (pv && !pr && (rvalid !== 1'b1 || rdata !== pd || rlast !== pl)) rd_stab++;
      if (rvalid === 1'b1) begin
        if (rd_lat < 0) rd_lat = cyc;
      end else if (rd_lat >= 0) begin
        rd_gaps++;
      end
      case (mode)
        0: rready = 1'b1;
        1: rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rvalid === 1'b1 && rready) begin
        rd_data[rd_count] = rdata;
        rd_last[rd_count] = rlast;
        rd_id = rid;
        rd_resp = rd_resp | rresp;
        rd_count++;
      end
      pv = rvalid; pr = rready; pd = rdata; pl = rlast;
      tick();
      cyc++;
    end
    rready = 1'b0;
    if (rd_count <= int'(len)) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout: got %0d beats, required %0d", rd_count, int'(len) + 1);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int last_at, input bit gaps);
    bit ok;
    logic hs;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd2; awvalid = 1'b1;
    ok = 1'b0;
    for (int g = 0; g < 50 && !ok; g++) begin
      hs = awready;
      tick();
      ok = hs;
    end
    awvalid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL aw_handshake: awready never seen, required 1");
      return;
    end
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        tick();
      end
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at); wid = 4'($urandom);
      ok = 1'b0;
      for (int g = 0; g < 50 && !ok; g++) begin
        hs = wready;
        tick();
        ok = hs;
      end
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL w_handshake: wready never seen on beat %0d, required 1", b);
        wvalid = 1'b0;
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int g = 0; g < 50 && bvalid !== 1'b1; g++) tick();
    if (bvalid !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout: bvalid %b, required 1", bvalid);
      return;
    end
    repeat ($urandom_range(0, 2)) tick();
    bready = 1'b1; wr_resp = bresp; wr_bid = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 000000", {arready, awready, wready, rvalid, rlast, bvalid});
    end
    n_tests++;
    if ({rdata, rresp, bresp, rid, bid} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", {rdata, rresp, bresp, rid, bid});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({arready, awready, wready} !== 3'b110) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 110", {arready, awready, wready});
    end
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h1000_0004, 8'd0, 2'b01, 4'h5, 0, 1'b0);
    model_write(32'h1000_0004, 8'd0, 2'b01);
    n_tests++;
    if ({wr_resp, wr_bid} !== {2'b00, 4'h5}) begin
      n_fail++;
      $display("FAIL single_b: got resp %b id %h, required 00 5", wr_resp, wr_bid);
    end
    do_read(32'h1000_0004, 8'd0, 2'b01, 4'hA, 0);
    n_tests++;
    if (rd_count !== 1 || rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_resp !== 2'b00 || rd_id !== 4'hA) begin
      n_fail++;
      $display("FAIL single_r: got n=%0d data %h last %b resp %b id %h, required 1 deadbeef 1 00 a",
               rd_count, rd_data[0], rd_last[0], rd_resp, rd_id);
    end
  endtask

  task automatic test_incr8();
    for (int b = 0; b < 8; b++) begin
      wd[b] = 32'h11111111 * (b + 1); ws[b] = 4'hF;
    end
    do_write(32'h20, 8'd7, 2'b01, 4'h2, 7, 1'b0);
    model_write(32'h20, 8'd7, 2'b01);
    n_tests++;
    if (wr_resp !== 2'b00) begin
      n_fail++; $display("FAIL incr8_bresp: got %b, required 00", wr_resp);
    end
    do_read(32'h20, 8'd7, 2'b01, 4'h7, 0);
    n_tests++;
    if (rd_count !== 8 || rd_gaps !== 0 || rd_lat !== LAT + 1) begin
      n_fail++;
      $display("FAIL incr8_timing: got n=%0d gaps=%0d lat=%0d, required 8 0 %0d", rd_count, rd_gaps, rd_lat, LAT + 1);
    end
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (rd_data[b] !== 32'h11111111 * (b + 1) || rd_last[b] !== (b == 7)) begin
        n_fail++;
        $display("FAIL incr8_beat%0d: got %h last %b, required %h last %b", b, rd_data[b], rd_last[b],
                 32'h11111111 * (b + 1), (b == 7));
      end
    end
  endtask

  task automatic test_strobes();
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(32'h40, 8'd0, 2'b01, 4'h1, 0, 1'b0);
    model_write(32'h40, 8'd0, 2'b01);
    wd[0] = 32'h12345678; ws[0] = 4'b0101;
    do_write(32'h40, 8'd0, 2'b01, 4'h1, 0, 1'b0);
    model_write(32'h40, 8'd0, 2'b01);
    do_read(32'h40, 8'd0, 2'b01, 4'h1, 0);
    n_tests++;
    if (rd_data[0] !== 32'hFF34FF78 || model_mem[16] !== 32'hFF34FF78) begin
      n_fail++;
      $display("FAIL strobes: got %h, required ff34ff78", rd_data[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = $urandom;
    for (int b = 0; b < 8; b++) begin
      wd[b] = $urandom; ws[b] = 4'hF;
    end
    do_write(a, 8'd7, 2'b01, 4'h3, 7, 1'b1);
    model_write(a, 8'd7, 2'b01);
    do_read(a, 8'd7, 2'b01, 4'h4, 1);
    n_tests++;
    if (rd_lat !== LAT + 1 || rd_stab !== 0 || rd_count !== 8 || rd_gaps !== 0) begin
      n_fail++;
      $display("FAIL backpressure: got lat=%0d unstable=%0d n=%0d gaps=%0d, required %0d 0 8 0",
               rd_lat, rd_stab, rd_count, rd_gaps, LAT + 1);
    end
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (rd_data[b] !== model_mem[beat_idx(a, 2'b01, b)] || rd_last[b] !== (b == 7)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h last %b, required %h", b, rd_data[b], rd_last[b],
                 model_mem[beat_idx(a, 2'b01, b)]);
      end
    end
  endtask

  task automatic test_protocol_error();
    for (int b = 0; b < 8; b++) begin
      wd[b] = 32'hA0A0_0000 + b; ws[b] = 4'hF;
    end
    do_write(32'h100, 8'd7, 2'b01, 4'h9, 3, 1'b0);
    model_write(32'h100, 8'd7, 2'b01);
    n_tests++;
    if ({wr_resp, wr_bid} !== {2'b10, 4'h9}) begin
      n_fail++; $display("FAIL proto_bresp: got %b id %h, required 10 9", wr_resp, wr_bid);
    end
    do_read(32'h100, 8'd7, 2'b01, 4'h0, 2);
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (rd_data[b] !== 32'hA0A0_0000 + b) begin
        n_fail++; $display("FAIL proto_beat%0d: got %h, required %h", b, rd_data[b], 32'hA0A0_0000 + b);
      end
    end
  endtask

  task automatic test_fixed_wrap();
    for (int b = 0; b < 4; b++) begin
      wd[b] = $urandom; ws[b] = 4'hF;
    end
    do_write(32'h200, 8'd3, 2'b00, 4'h6, 3, 1'b0);
    model_write(32'h200, 8'd3, 2'b00);
    do_read(32'h200, 8'd3, 2'b00, 4'h6, 0);
    for (int b = 0; b < 4; b++) begin
      n_tests++;
      if (rd_data[b] !== wd[3]) begin
        n_fail++; $display("FAIL fixed_beat%0d: got %h, required %h", b, rd_data[b], wd[3]);
      end
    end
    for (int b = 0; b < 4; b++) begin
      wd[b] = $urandom; ws[b] = 4'hF;
    end
    do_write(32'hFFFF_0FF8, 8'd3, 2'b01, 4'hC, 3, 1'b0);
    model_write(32'hFFFF_0FF8, 8'd3, 2'b01);
    do_read(32'h8000_0000, 8'd1, 2'b11, 4'hD, 0);
    for (int b = 0; b < 2; b++) begin
      n_tests++;
      if (rd_data[b] !== wd[b + 2]) begin
        n_fail++; $display("FAIL wrap_beat%0d: got %h, required %h", b, rd_data[b], wd[b + 2]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] old_v, new_v;
    wd[0] = $urandom; ws[0] = 4'hF;
    do_write(32'h500, 8'd0, 2'b01, 4'h1, 0, 1'b0);
    model_write(32'h500, 8'd0, 2'b01);
    old_v = model_mem[beat_idx(32'h500, 2'b01, 0)];
    new_v = ~old_v;
    n_tests++;
    if ({arready, awready} !== 2'b11) begin
      n_fail++; $display("FAIL coll_idle: got %b, required 11", {arready, awready});
    end
    araddr = 32'h500; arlen = 8'd0; arburst = 2'b01; arid = 4'hE; arvalid = 1'b1;
    awaddr = 32'h500; awlen = 8'd0; awburst = 2'b01; awid = 4'hF; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (LAT) tick();
    wvalid = 1'b1; wdata = new_v; wstrb = 4'hF; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_old: got rvalid %b data %h bvalid %b, required 1 %h 1", rvalid, rdata, bvalid, old_v);
    end
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    wd[0] = new_v;
    model_write(32'h500, 8'd0, 2'b01);
    do_read(32'h500, 8'd0, 2'b01, 4'h2, 0);
    n_tests++;
    if (rd_data[0] !== new_v) begin
      n_fail++; $display("FAIL collision_new: got %h, required %h", rd_data[0], new_v);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    ar_req(32'h20, 8'd7, 2'b01, 4'h3, ok);
    for (int g = 0; g < 20 && rvalid !== 1'b1; g++) tick();
    n_tests++;
    if (rvalid !== 1'b1) begin
      n_fail++; $display("FAIL midrd_valid: got %b, required 1", rvalid);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({rvalid, rlast, arready, awready, wready, bvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrd_reset: got %b, required 000000", {rvalid, rlast, arready, awready, wready, bvalid});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({arready, awready} !== 2'b11) begin
      n_fail++; $display("FAIL midrd_ready: got %b, required 11", {arready, awready});
    end
    do_read(32'h20, 8'd7, 2'b01, 4'h3, 0);
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (rd_data[b] !== model_mem[beat_idx(32'h20, 2'b01, b)]) begin
        n_fail++;
        $display("FAIL retained_beat%0d: got %h, required %h", b, rd_data[b], model_mem[beat_idx(32'h20, 2'b01, b)]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0] len;
    logic [1:0] burst;
    logic [3:0] id;
    int last_at;
    for (int t = 0; t < 24; t++) begin
      a = $urandom; burst = 2'($urandom); id = 4'($urandom);
      case ($urandom_range(0, 3))
        0: len = 8'd0;
        1: len = 8'd7;
        default: len = 8'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= int'(len); b++) begin
          wd[b] = $urandom; ws[b] = 4'($urandom);
        end
        last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
        do_write(a, len, burst, id, last_at, 1'b1);
        model_write(a, len, burst);
        n_tests++;
        if ({wr_resp, wr_bid} !== {((last_at != int'(len)) ? 2'b10 : 2'b00), id}) begin
          n_fail++;
          $display("FAIL rand_b%0d: got %b id %h, required err=%0d id %h", t, wr_resp, wr_bid, last_at != int'(len), id);
        end
      end else begin
        do_read(a, len, burst, id, 2);
        for (int b = 0; b <= int'(len); b++) begin
          n_tests++;
          if (rd_data[b] !== model_mem[beat_idx(a, burst, b)] || rd_last[b] !== (b == int'(len)) || rd_id !== id) begin
            n_fail++;
            $display("FAIL rand_r%0d_beat%0d: got %h last %b id %h, required %h", t, b, rd_data[b], rd_last[b],
                     rd_id, model_mem[beat_idx(a, burst, b)]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arlock = 2'b00;
    arcache = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awlock = 2'b00;
    awcache = 4'd0; awprot = 3'd0; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 32'd0;
    test_reset();
    test_single();
    test_incr8();
    test_strobes();
    test_backpressure();
    test_protocol_error();
    test_fixed_wrap();
    test_collision();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder (slave) backed by a word-addressed on-chip memory; it answers the burst/word requests issued by the cache-side AXI bridge.
- Serves single-word and 8-beat INCR bursts on independent read and write channels.
- Used as the memory model in cache/bridge simulation and as a small on-chip RAM in SoC builds.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; power of two.
- READ_LATENCY, 0, idle cycles between AR handshake and first rvalid (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- arid / araddr / arlen / arsize / arburst  in  4/32/8/3/2  read request
- arlock / arcache / arprot  in  2/4/3  accepted, ignored
- arvalid in 1; arready out 1
- rid / rdata / rresp / rlast / rvalid  out  4/32/2/1/1  read data; rready in 1
- awid / awaddr / awlen / awsize / awburst  in  4/32/8/3/2  write request
- awlock / awcache / awprot  in  2/4/3  ignored
- awvalid in 1; awready out 1
- wid / wdata / wstrb / wlast / wvalid  in  4/32/4/1/1  write data; wready out 1
- bid / bresp / bvalid  out  4/2/1; bready in 1

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: arready, awready, wready, rvalid, rlast, bvalid = 0; rdata = 0; rresp = 0; bresp = 0; rid = 0; bid = 0.
- Memory contents are not cleared by reset. Memory is zero-initialised at time 0.
- Index rule: idx = addr[log2(MEM_WORDS)+1:2]. Higher address bits alias. Byte offset is ignored.
- Burst rule: burst == 2'b00 (FIXED) holds idx for every beat. Any other burst value is INCR: idx+1 per beat, wrapping modulo MEM_WORDS. arsize/awsize are not checked; a full word is always returned and written.
- Read FSM, states R_IDLE / R_WAIT / R_DATA:
  - R_IDLE: arready = 1 (first asserted the cycle after rst deasserts).
  - On arvalid & arready: latch id, idx, len; clear beat counter; arready <= 0; go to R_WAIT if READ_LATENCY > 0, otherwise R_DATA.
  - R_WAIT: count READ_LATENCY cycles, then go to R_DATA.
  - Entering R_DATA or advancing a beat: rvalid <= 1; rdata <= mem[idx] read at that edge; rlast <= (beat == len); rresp = 2'b00; rid = latched id.
  - rvalid, rdata and rlast hold stable until rready is seen.
  - On rvalid & rready with rlast = 0: next beat is presented the following cycle (back-to-back, no bubble).
  - On rvalid & rready with rlast = 1: rvalid <= 0, rlast <= 0, arready <= 1, go to R_IDLE.
- Write FSM, states W_IDLE / W_DATA / W_RESP:
  - W_IDLE: awready = 1.
  - On awvalid & awready: latch id, idx, len; clear error flag; awready <= 0; wready <= 1; go to W_DATA.
  - W_DATA, per wvalid & wready: write byte lanes of mem[idx] where wstrb[i] = 1; advance idx.
  - If wlast != (beat == len), set the error flag; the data is still written.
  - The burst ends at beat == len regardless of wlast. wid is ignored.
  - At the final beat: wready <= 0; bvalid <= 1; bid = latched id; bresp = error ? 2'b10 (SLVERR) : 2'b00; go to W_RESP.
  - W_RESP: hold bvalid until bready. Then bvalid <= 0, awready <= 1, go to W_IDLE.
  - Handshake throughput is 1 beat/cycle while wvalid is held.
- Concurrency: the read and write FSMs are fully independent.
  - If a read beat is sampled at the same edge a write commits to that word, the read returns the old data.
  - The write is visible to any beat sampled at a later edge.
- Reset mid-burst: both FSMs return to idle and every valid/ready output drops to its reset value at the next edge. Partially written words keep the beats already written.
- Early arvalid/awvalid (request presented while the channel is busy): not accepted; the master holds it until the ready output returns.

Test Plan:
- Single write, then read:
  - Write awaddr=0x1000_0004, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1 → bvalid with bresp=0 and bid=awid.
  - Then read araddr=0x1000_0004, arlen=0 → rdata=0xDEADBEEF, rlast=1, rresp=0.
- 8-beat INCR round trip:
  - Write burst awaddr=0x20, awlen=7, data 0x11111111..0x88888888.
  - Read arlen=7 from 0x20 with rready stuck at 1 → eight consecutive rvalid cycles, data in order, rlast only on the 8th.
- Byte strobes: prefill 0xFFFFFFFF; write 0x12345678 with wstrb=4'b0101 → read returns 0xFF34FF78.
- Backpressure and latency: READ_LATENCY=3, rready toggling 1/0.
  - First rvalid appears exactly 4 cycles after the AR handshake.
  - rdata and rlast stay stable while rready=0; no beat is lost or duplicated.
- Protocol error: awlen=7 with wlast asserted on beat 3 → all 8 beats written; bresp=2'b10.
- Reset and collision:
  - rst asserted mid-read-burst → rvalid=0 and arready=0 next cycle, arready=1 after rst deasserts, memory retained.
  - Simultaneous same-word read/write → read returns the old value.
